// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared definitions for the FFT output reorder path.
//   DEF_DATA_W / DEF_LOG2N : default sample width and log2 frame length
//   BANK_*                 : ping-pong bank state encoding
//   bitrev()               : reverse the low w bits of an index (w <= 16)
package fft_bitrev_reorder_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_LOG2N  = 4;

  localparam logic [1:0] BANK_EMPTY    = 2'd0;
  localparam logic [1:0] BANK_FILLING  = 2'd1;
  localparam logic [1:0] BANK_FULL     = 2'd2;
  localparam logic [1:0] BANK_DRAINING = 2'd3;

  // Shifts bits out of the LSB of idx into the LSB of the result, so the low
  // w bits come back mirrored and everything above w stays zero.
  function automatic logic [15:0] bitrev(input logic [15:0] idx, input int w);
    logic [15:0] r;
    logic [15:0] t;
    r = '0;
    t = idx;
    for (int i = 0; i < 16; i++) begin
      if (i < w) begin
        r = {r[14:0], t[0]};
        t = t >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Push/stall sample stream: one complex sample moves on a rising edge where
// push=1 and stall=0.
//   push  : sample valid        (master -> slave)
//   re/im : signed sample parts (master -> slave)
//   stall : back-pressure       (slave -> master)
interface fft_bitrev_reorder_if
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic                     push;
  logic signed [DATA_W-1:0] re;
  logic signed [DATA_W-1:0] im;
  logic                     stall;

  modport master (output push, re, im, input stall);
  modport slave  (input push, re, im, output stall);
endinterface

// File: rtl/fft_bitrev_reorder_pingpong_ram.sv
// Two-bank, one-write/one-read memory with synchronous read.
//   clk                  : clock
//   we/wbank/waddr/wdata : write port
//   re/rbank/raddr       : read request; rdata is valid the cycle after re
//                          and holds while re stays low
module fft_pingpong_ram #(
  parameter int W  = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic          wbank,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic          rbank,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [0:(2<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[{wbank, waddr}] <= wdata;
    if (re) rdata <= mem[{rbank, raddr}];
  end
endmodule

// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order reorder buffer for 2**LOG2N point FFT frames.
//   clk, reset : clock, async active-low reset
//   in_if      : upstream stream (slave), stall from registered bank state
//   out_if     : downstream stream (master), registered outputs
//   out_first  : high with out_if.push on bin 0 of each frame
// Writes land at bitrev(k); reads walk addresses 0..N-1. The read path is
// two stages (RAM read register, then output register) so a stalled output
// never loses the word already fetched from the RAM.
module fft_bitrev_reorder
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LOG2N  = DEF_LOG2N
) (
  input  logic clk,
  input  logic reset,
  fft_bitrev_reorder_if.slave  in_if,
  fft_bitrev_reorder_if.master out_if,
  output logic out_first
);
  localparam logic [LOG2N-1:0] CNT_LAST = '1;
  localparam logic [LOG2N-1:0] CNT_ONE  = LOG2N'(1);

  logic [1:0][1:0]    bank_st_q, bank_st_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0]   wr_cnt_q,  wr_cnt_d;
  logic [LOG2N-1:0]   rd_cnt_q,  rd_cnt_d;
  logic               rd_vld_q,  rd_vld_d;
  logic               rd_first_q, rd_first_d;
  logic               out_push_q, out_push_d;
  logic               out_first_q, out_first_d;
  logic [DATA_W-1:0]  out_re_q, out_re_d;
  logic [DATA_W-1:0]  out_im_q, out_im_d;

  logic               in_stall, wr_acc, rd_avail, out_ld, mv, rd_en;
  logic [LOG2N-1:0]   wr_addr;
  logic [2*DATA_W-1:0] ram_rdata;

  // Write bank busy means both banks still hold unread data.
  assign in_stall = (bank_st_q[wr_bank_q] == BANK_FULL) ||
                    (bank_st_q[wr_bank_q] == BANK_DRAINING);
  assign wr_acc   = in_if.push & ~in_stall;
  assign wr_addr  = LOG2N'(bitrev(16'(wr_cnt_q), LOG2N));

  // DRAINING always has words left: reading the last one empties the bank.
  assign rd_avail = (bank_st_q[rd_bank_q] == BANK_FULL) ||
                    (bank_st_q[rd_bank_q] == BANK_DRAINING);
  assign out_ld   = ~out_push_q | ~out_if.stall;
  assign mv       = rd_vld_q & out_ld;
  assign rd_en    = rd_avail & (~rd_vld_q | mv);

  always_comb begin
    bank_st_d  = bank_st_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    rd_first_d = rd_first_q;
    // Write and read never touch the same bank in one cycle: the write bank
    // is EMPTY/FILLING, the read bank FULL/DRAINING.
    if (wr_acc) begin
      wr_cnt_d = wr_cnt_q + CNT_ONE;
      if (wr_cnt_q == CNT_LAST) begin
        bank_st_d[wr_bank_q] = BANK_FULL;
        wr_bank_d            = ~wr_bank_q;
      end else begin
        bank_st_d[wr_bank_q] = BANK_FILLING;
      end
    end
    if (rd_en) begin
      rd_cnt_d   = rd_cnt_q + CNT_ONE;
      rd_first_d = (rd_cnt_q == '0);
      if (rd_cnt_q == CNT_LAST) begin
        bank_st_d[rd_bank_q] = BANK_EMPTY;
        rd_bank_d            = ~rd_bank_q;
      end else begin
        bank_st_d[rd_bank_q] = BANK_DRAINING;
      end
    end
  end

  always_comb begin
    rd_vld_d    = rd_en | (rd_vld_q & ~mv);
    out_push_d  = mv | (out_push_q & out_if.stall);
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    // out_first only ever shows alongside a valid word.
    out_first_d = out_first_q & out_push_q & out_if.stall;
    if (mv) begin
      out_re_d    = ram_rdata[2*DATA_W-1:DATA_W];
      out_im_d    = ram_rdata[DATA_W-1:0];
      out_first_d = rd_first_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_st_q   <= {BANK_EMPTY, BANK_EMPTY};
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      rd_vld_q    <= 1'b0;
      rd_first_q  <= 1'b0;
      out_push_q  <= 1'b0;
      out_first_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      bank_st_q   <= bank_st_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_vld_q    <= rd_vld_d;
      rd_first_q  <= rd_first_d;
      out_push_q  <= out_push_d;
      out_first_q <= out_first_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  fft_pingpong_ram #(.W(2*DATA_W), .AW(LOG2N)) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .wbank (wr_bank_q),
    .waddr (wr_addr),
    .wdata ({in_if.re, in_if.im}),
    .re    (rd_en),
    .rbank (rd_bank_q),
    .raddr (rd_cnt_q),
    .rdata (ram_rdata)
  );

  assign in_if.stall = in_stall;
  assign out_if.push = out_push_q;
  assign out_if.re   = out_re_q;
  assign out_if.im   = out_im_q;
  assign out_first   = out_first_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Randomized bench for fft_bitrev_reorder with a frame-level reference model:
// each accepted 16-sample frame is queued in natural order (output j is
// input sample bitrev(j)) and every output transfer is popped and compared.
module tb_fft_bitrev_reorder;
  localparam int DW = 16;
  localparam int NP = 16;

  logic clk = 1'b0;
  logic reset;
  logic out_first;

  fft_bitrev_reorder_if #(.DATA_W(DW)) in_if ();
  fft_bitrev_reorder_if #(.DATA_W(DW)) out_if ();

  fft_bitrev_reorder #(.DATA_W(DW), .LOG2N(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_if     (in_if),
    .out_if    (out_if),
    .out_first (out_first)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int stall_seen = 0;
  int acc_tot = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic int brev(input int j);
    int r = 0;
    for (int b = 0; b < 4; b++) r = r * 2 + ((j / (1 << b)) % 2);
    return r;
  endfunction

  // ---------------- reference model / scoreboard ----------------
  logic [32:0] exp_q[$];
  logic [31:0] fr [NP];
  int          wcnt = 0;
  logic        hold_v = 1'b0;
  logic [33:0] hold_d;

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      wcnt   = 0;
      hold_v = 1'b0;
    end else begin
      if (hold_v)
        chk("hold", {out_if.push, out_first, out_if.re, out_if.im}, hold_d);
      hold_v = out_if.push && out_if.stall;
      hold_d = {out_if.push, out_first, out_if.re, out_if.im};
      if (!out_if.push) chk("first_idle", out_first, 0);
      if (out_if.push && !out_if.stall) begin
        if (exp_q.size() == 0) chk("extra_out", 1, 0);
        else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("data", {out_if.re, out_if.im}, e[31:0]);
          chk("first", out_first, e[32]);
        end
      end
      if (in_if.push && !in_if.stall) begin
        fr[wcnt] = {in_if.re, in_if.im};
        wcnt++;
        acc_tot++;
        if (wcnt == NP) begin
          for (int j = 0; j < NP; j++) exp_q.push_back({(j == 0), fr[brev(j)]});
          wcnt = 0;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [15:0] r, input logic [15:0] i);
    int to = 0;
    in_if.push = 1'b1;
    in_if.re   = r;
    in_if.im   = i;
    @(negedge clk);
    while (in_if.stall && to < 2000) begin
      stall_seen++;
      to++;
      @(negedge clk);
    end
    if (to >= 2000) chk("send_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_if.push = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset = 1'b0;
    in_if.push = 1'b0; in_if.re = '0; in_if.im = '0;
    out_if.stall = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_push",  out_if.push, 0);
    chk("rst_re",    out_if.re, 0);
    chk("rst_im",    out_if.im, 0);
    chk("rst_first", out_first, 0);
    chk("rst_stall", in_if.stall, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // ordering: re=k, im=-k
    for (int k = 0; k < NP; k++) send(16'(k), 16'(-k));
    idle(30);
    chk("order_left", exp_q.size(), 0);

    // impulse with latency check
    for (int k = 0; k < NP; k++) send((k == 0) ? 16'h7fff : 16'h0, 16'h0);
    in_if.push = 1'b0;
    @(posedge clk); #1;
    chk("lat_early", out_if.push, 0);
    @(posedge clk); #1;
    chk("lat_push",  out_if.push, 1);
    chk("lat_re",    out_if.re, 16'h7fff);
    chk("lat_first", out_first, 1);
    idle(30);
    chk("imp_left", exp_q.size(), 0);

    // back-to-back frames
    stall_seen = 0;
    fork
      begin
        for (int n = 0; n < 4 * NP; n++) send(16'($urandom), 16'($urandom));
        in_if.push = 1'b0;
      end
      begin
        int t = 0;
        while (!out_if.push && t < 200) begin @(posedge clk); #1; t++; end
        chk("b2b_start", (t < 200), 1);
        for (int n = 0; n < 4 * NP; n++) begin
          chk("b2b_gap", out_if.push, 1);
          @(posedge clk); #1;
        end
      end
    join
    chk("b2b_stall", stall_seen, 0);
    idle(30);
    chk("b2b_left", exp_q.size(), 0);

    // back-pressure: hold output for 40 cycles while pushing 3 frames
    base = acc_tot;
    out_if.stall = 1'b1;
    fork
      begin
        for (int n = 0; n < 3 * NP; n++) send(16'($urandom), 16'($urandom));
        in_if.push = 1'b0;
      end
      begin
        int t = 0;
        while (!in_if.stall && t < 39) begin @(posedge clk); #1; t++; end
        chk("bp_stall_rise", in_if.stall, 1);
        chk("bp_accepts", acc_tot - base, 32);
      end
      begin
        repeat (40) @(posedge clk);
        #1;
        out_if.stall = 1'b0;
      end
    join
    idle(60);
    chk("bp_left", exp_q.size(), 0);

    // random gaps and random stall
    fork
      begin
        for (int n = 0; n < 6 * NP; n++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
          send(16'($urandom), 16'($urandom));
        end
        in_if.push = 1'b0;
      end
      begin
        repeat (500) begin
          out_if.stall = ($urandom_range(0, 1) == 1);
          @(posedge clk); #1;
        end
        out_if.stall = 1'b0;
      end
    join
    idle(60);
    chk("rand_left", exp_q.size(), 0);

    // reset after 7 accepts of frame 2, output of frame 1 in flight
    for (int n = 0; n < NP + 7; n++) send(16'($urandom), 16'($urandom));
    in_if.push = 1'b0;
    chk("pre_rst_push", out_if.push, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_push",  out_if.push, 0);
    chk("mid_rst_stall", in_if.stall, 0);
    chk("mid_rst_first", out_first, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < NP; n++) send(16'($urandom), 16'($urandom));
    idle(40);
    chk("final_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
